// File: rtl/uart_pkt_pkg.sv
// Shared types and constants for the UART packet scheduler.
package uart_pkt_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RDY = 2'd2
  } state_t;

  localparam int   SAMPLE_W = 10;
  localparam int   WORD_W   = 6;
  localparam int   PAY_W    = WORD_W - 1;
  localparam logic HDR_MARK = 1'b1;
  localparam int   N_WORDS  = 3;

endpackage

// File: rtl/uart_pkt_sched_rr_arbiter.sv
// Combinational round-robin picker: first set req bit after ptr, wrapping.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan from the farthest slot back to ptr+1 so the nearest hit wins.
  always_comb begin
    int c;
    idx = '0;
    any = 1'b0;
    c   = 0;
    for (int k = N; k >= 1; k--) begin
      c = (int'(ptr) + k) % N;
      if (req[IW'(c)]) begin
        any = 1'b1;
        idx = IW'(c);
      end
    end
    grant = any ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/uart_pkt_sched.sv
// Round-robin sample scheduler feeding a 6-bit-word UART as 3-word packets.
module uart_pkt_sched
  import uart_pkt_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int CH_W        = 4,
  parameter int TIMEOUT_CYC = 8192
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic [N_CH-1:0]          req,
  input  logic [SAMPLE_W*N_CH-1:0] sample,
  output logic [N_CH-1:0]          ack,
  output logic                     uart_wreq,
  output logic [WORD_W-1:0]        uart_wdata,
  input  logic                     uart_rdy,
  output logic                     busy,
  output logic [CH_W-1:0]          last_ch,
  output logic                     err
);

  localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

  state_t              state, state_n;
  logic [PTR_W-1:0]    ptr, gidx;
  logic [N_CH-1:0]     grant;
  logic                any;
  logic [1:0]          idx;
  logic [CNT_W-1:0]    cnt;
  logic [SAMPLE_W-1:0] sq;
  logic [WORD_W-1:0]   word;
  logic                grant_en, word_done, tmo;
  logic [SAMPLE_W-1:0] smp [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_smp
    assign smp[i] = sample[SAMPLE_W*i +: SAMPLE_W];
  end

  rr_arbiter #(.N(N_CH)) u_arb (
    .req  (req),
    .ptr  (ptr),
    .grant(grant),
    .idx  (gidx),
    .any  (any)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_n;
  end

  // The first WAIT_RDY cycle (cnt==0) ignores rdy: the transmitter is still dropping it.
  always_comb begin
    state_n   = state;
    grant_en  = 1'b0;
    word_done = 1'b0;
    tmo       = 1'b0;
    case (state)
      IDLE: if (any) begin
        grant_en = 1'b1;
        state_n  = ISSUE;
      end
      ISSUE: if (uart_rdy) state_n = WAIT_RDY;
      WAIT_RDY: begin
        if (cnt != '0 && uart_rdy) begin
          word_done = 1'b1;
          state_n   = (idx == 2'(N_WORDS - 1)) ? IDLE : ISSUE;
        end else if (cnt == CNT_MAX) begin
          tmo     = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ptr     <= PTR_W'(N_CH - 1);
      idx     <= '0;
      cnt     <= '0;
      ack     <= '0;
      err     <= 1'b0;
      last_ch <= '0;
      sq      <= '0;
    end else begin
      ack <= grant_en ? grant : '0;
      err <= tmo;
      if (grant_en) begin
        sq      <= smp[gidx];
        ptr     <= gidx;
        last_ch <= CH_W'(gidx);
        idx     <= '0;
      end
      if (state == ISSUE)         cnt <= '0;
      else if (state == WAIT_RDY) cnt <= cnt + CNT_W'(1);
      if (word_done && state_n == ISSUE) idx <= idx + 2'd1;
    end
  end

  always_comb begin
    word = '0;
    case (idx)
      2'd0:    word = {HDR_MARK, last_ch, 1'b0};
      2'd1:    word = {1'b0, sq[SAMPLE_W-1 -: PAY_W]};
      default: word = {1'b0, sq[PAY_W-1:0]};
    endcase
  end

  assign busy       = (state != IDLE);
  assign uart_wreq  = (state == ISSUE) && uart_rdy;
  assign uart_wdata = (state == ISSUE) ? word : '0;

endmodule
